// File: rtl/cc_cond_eval.sv
// cc_cond_eval: condition-code register plus tagged condition evaluator.
//
// Latches N/Z/V/C from the adder/subtractor into a CCR and serves tagged
// evaluation requests over valid/ready. Each accepted request pushes a
// {taken, tag} result into a 2-entry response FIFO.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cc_we, cc{n,z,v,c}_in        CCR write enable and flag inputs
//   req_valid/req_ready          request handshake; req_cond, req_tag payload
//   rsp_valid/rsp_ready          response handshake; rsp_taken, rsp_tag payload
//   flags_out, flags_valid       registered CCR {N,Z,V,C}, written-since-reset
//   taken_cnt                    saturating count of taken responses popped
module cc_cond_eval #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cc_we,
  input  logic             ccn_in,
  input  logic             ccz_in,
  input  logic             ccv_in,
  input  logic             ccc_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_taken,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [3:0]       flags_out,
  output logic             flags_valid,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [3:0]       ccr_q;
  logic             flags_valid_q;
  logic             taken_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic [3:0] eff_flags;
  logic       f_n, f_z, f_v, f_c;
  logic       cond_true;
  logic       push;
  logic       pop;

  // Forward a same-cycle CCR write so back-to-back compare/branch works.
  always_comb begin
    eff_flags = cc_we ? {ccn_in, ccz_in, ccv_in, ccc_in} : ccr_q;
    f_n = eff_flags[3];
    f_z = eff_flags[2];
    f_v = eff_flags[1];
    f_c = eff_flags[0];
  end

  always_comb begin
    cond_true = 1'b0;
    case (req_cond)
      4'd0:  cond_true = f_z;
      4'd1:  cond_true = ~f_z;
      4'd2:  cond_true = f_c;
      4'd3:  cond_true = ~f_c;
      4'd4:  cond_true = f_n;
      4'd5:  cond_true = ~f_n;
      4'd6:  cond_true = f_v;
      4'd7:  cond_true = ~f_v;
      4'd8:  cond_true = f_c & ~f_z;
      4'd9:  cond_true = ~f_c | f_z;
      4'd10: cond_true = (f_n == f_v);
      4'd11: cond_true = (f_n != f_v);
      4'd12: cond_true = ~f_z & (f_n == f_v);
      4'd13: cond_true = f_z | (f_n != f_v);
      4'd14: cond_true = 1'b1;
      4'd15: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  // req_ready deliberately ignores rsp_ready: no comb path downstream-to-upstream.
  assign req_ready = (flags_valid_q | cc_we) & (count_q != 2'd2);
  assign rsp_valid = (count_q != 2'd0);
  assign push      = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ccr_q         <= 4'b0000;
      flags_valid_q <= 1'b0;
      taken_q       <= '{default: 1'b0};
      tag_q         <= '{default: '0};
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      taken_cnt_q   <= '0;
    end else begin
      if (cc_we) begin
        ccr_q         <= {ccn_in, ccz_in, ccv_in, ccc_in};
        flags_valid_q <= 1'b1;
      end
      if (push) begin
        taken_q[wr_ptr_q] <= cond_true;
        tag_q[wr_ptr_q]   <= req_tag;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (rsp_taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
          taken_cnt_q <= taken_cnt_q + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head payload is masked while the FIFO is empty.
  assign rsp_taken   = rsp_valid & taken_q[rd_ptr_q];
  assign rsp_tag     = rsp_valid ? tag_q[rd_ptr_q] : '0;
  assign flags_out   = ccr_q;
  assign flags_valid = flags_valid_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_cc_cond_eval.sv
// Self-checking bench for cc_cond_eval: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model every cycle.
module tb_cc_cond_eval;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cc_we;
  logic [3:0] flags_in;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_cond;
  logic [3:0] req_tag;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_taken;
  logic [3:0] rsp_tag;
  logic [3:0] flags_out;
  logic       flags_valid;
  logic [7:0] taken_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       taken;
    logic [3:0] tag;
  } ent_t;

  // Reference model state
  ent_t       m_q[$];
  logic [3:0] m_ccr = 4'b0;
  logic       m_fv = 1'b0;
  int         m_cnt = 0;
  logic [3:0] got_tags[$];

  always #5 clk = ~clk;

  cc_cond_eval #(.TAG_W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cc_we      (cc_we),
    .ccn_in     (flags_in[3]),
    .ccz_in     (flags_in[2]),
    .ccv_in     (flags_in[1]),
    .ccc_in     (flags_in[0]),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cond   (req_cond),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_taken  (rsp_taken),
    .rsp_tag    (rsp_tag),
    .flags_out  (flags_out),
    .flags_valid(flags_valid),
    .taken_cnt  (taken_cnt)
  );

  // Conditions come in complementary pairs: odd codes invert the even base.
  function automatic logic eval_m(input logic [3:0] f, input logic [3:0] c);
    logic n, z, v, cy, base;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Check outputs against the model, then advance one clock and update it.
  task automatic cycle(input bit do_chk = 1'b1);
    logic m_ready, m_rv, m_push, m_pop;
    ent_t head;
    #1;
    m_ready = (m_fv || cc_we) && (m_q.size() < 2);
    m_rv    = (m_q.size() != 0);
    head    = m_rv ? m_q[0] : '0;
    if (do_chk) begin
      check("req_ready", req_ready, m_ready);
      check("rsp_valid", rsp_valid, m_rv);
      check("rsp_taken", rsp_taken, head.taken);
      check("rsp_tag", rsp_tag, head.tag);
      check("flags_out", flags_out, m_ccr);
      check("flags_valid", flags_valid, m_fv);
      check("taken_cnt", taken_cnt, m_cnt);
    end
    m_push = req_valid && m_ready;
    m_pop  = m_rv && rsp_ready;
    if (m_pop && rst_n) got_tags.push_back(rsp_tag);
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_ccr = 4'b0;
      m_fv  = 1'b0;
      m_cnt = 0;
    end else begin
      if (m_pop) begin
        if (head.taken && m_cnt < 255) m_cnt++;
        void'(m_q.pop_front());
      end
      if (m_push) m_q.push_back({eval_m(cc_we ? flags_in : m_ccr, req_cond), req_tag});
      if (cc_we) begin
        m_ccr = flags_in;
        m_fv  = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Single request into an empty FIFO, check result, then drain it.
  task automatic single_req(input string name, input logic [3:0] c, input logic exp);
    req_valid = 1'b1; req_cond = c; req_tag = c; rsp_ready = 1'b0;
    cycle();
    req_valid = 1'b0;
    check(name, rsp_taken, exp);
    rsp_ready = 1'b1;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; cc_we = 1'b0; flags_in = 4'b0; req_valid = 1'b0;
    req_cond = 4'd0; req_tag = 4'd0; rsp_ready = 1'b0;
    cycle(1'b0);
    cycle();
    rst_n = 1'b1;

    // Stall before any CCR write, even for AL
    req_valid = 1'b1; req_cond = 4'd14; req_tag = 4'd9;
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", req_ready, 1'b0);
      cycle();
    end
    check("stall_rsp_valid", rsp_valid, 1'b0);

    // Forwarded flags used on the same cycle as the CCR write
    cc_we = 1'b1; flags_in = 4'b0101; req_cond = 4'd0; req_tag = 4'd3;
    cycle();
    cc_we = 1'b0; req_valid = 1'b0;
    check("fwd_rsp_valid", rsp_valid, 1'b1);
    check("fwd_rsp_taken", rsp_taken, 1'b1);
    check("fwd_rsp_tag", rsp_tag, 4'd3);
    check("fwd_flags_out", flags_out, 4'b0101);
    rsp_ready = 1'b1;
    cycle();

    // Signed vs unsigned: 0x80-0x01
    cc_we = 1'b1; flags_in = 4'b0011;
    cycle();
    cc_we = 1'b0;
    single_req("ge_0x80m1", 4'd10, 1'b0);
    single_req("lt_0x80m1", 4'd11, 1'b1);
    single_req("hs_0x80m1", 4'd2, 1'b1);
    single_req("hi_0x80m1", 4'd8, 1'b1);
    // 0x01-0x02
    cc_we = 1'b1; flags_in = 4'b1000;
    cycle();
    cc_we = 1'b0;
    single_req("lo_1m2", 4'd3, 1'b1);
    single_req("gt_1m2", 4'd12, 1'b0);

    // Backpressure: third request held until the FIFO drains
    got_tags.delete();
    rsp_ready = 1'b0; req_valid = 1'b1; req_cond = 4'd14;
    req_tag = 4'd1; cycle();
    req_tag = 4'd2; cycle();
    req_tag = 4'd3;
    check("bp_full_ready", req_ready, 1'b0);
    cycle(); cycle();
    check("bp_hold_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    cycle(); cycle();
    req_valid = 1'b0;
    cycle();
    check("bp_pop_count", got_tags.size(), 3);
    if (got_tags.size() == 3) begin
      check("bp_order0", got_tags[0], 4'd1);
      check("bp_order1", got_tags[1], 4'd2);
      check("bp_order2", got_tags[2], 4'd3);
    end

    // Simultaneous push and pop at count 1
    req_valid = 1'b1; rsp_ready = 1'b1; req_cond = 4'd14; req_tag = 4'd0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      req_cond = (i % 3 == 0) ? 4'd15 : 4'd14;
      req_tag = 4'(i);
      check("pp_rsp_valid", rsp_valid, 1'b1);
      check("pp_req_ready", req_ready, 1'b1);
      cycle();
    end

    // Drive the counter into saturation
    for (int i = 0; i < 400; i++) begin
      req_cond = (i % 4 == 3) ? 4'd15 : 4'd14;
      req_tag = 4'(i);
      cycle();
    end
    check("cnt_saturated", taken_cnt, 8'd255);

    // Randomized traffic against the model
    rst_n = 1'b0; req_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      cc_we     = ($urandom_range(0, 3) == 0);
      flags_in  = 4'($urandom);
      req_valid = ($urandom_range(0, 2) != 0);
      req_cond  = 4'($urandom);
      req_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Reset mid-operation with a full FIFO
    rst_n = 1'b1; rsp_ready = 1'b0; req_valid = 1'b0;
    cc_we = 1'b1; flags_in = 4'b1010;
    cycle();
    cc_we = 1'b0; rsp_ready = 1'b1;
    cycle(); cycle();
    rsp_ready = 1'b0; req_valid = 1'b1; req_cond = 4'd4; req_tag = 4'd7;
    cycle(); cycle();
    check("pre_rst_flags", flags_out, 4'b1010);
    check("pre_rst_full", req_ready, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; req_cond = 4'd14;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_flags_out", flags_out, 4'b0000);
    check("rst_flags_valid", flags_valid, 1'b0);
    check("rst_taken_cnt", taken_cnt, 8'd0);
    for (int i = 0; i < 3; i++) begin
      check("rst_stall", req_ready, 1'b0);
      cycle();
    end
    cc_we = 1'b1; flags_in = 4'b0000;
    #1;
    check("rst_unstall", req_ready, 1'b1);
    cycle();
    cc_we = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
